seg7_cc_monitor: RTL and testbench
==================================

SEG7_CC_MONITOR -- requirements
Module: seg7_cc_monitor

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4: number of multiplexed common-cathode digits observed.
REQ-002 SHALL have parameter STABLE_CYCLES, default 16 (range 2..255): consecutive identical synchronized samples required before a capture.
REQ-003 SHALL have port clk50MHz, input, 1 bit: the single 50 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Segments, input, 7 bits: segment lines, active-high, bit order {g,f,e,d,c,b,a}.
REQ-006 SHALL have port dp, input, 1 bit: decimal point line, active-high.
REQ-007 SHALL have port Digit_sel, input, N_DIGITS bits: cathode selects, active-low; exactly one low means a valid selection.
REQ-008 SHALL have port bcd_out, output, 4*N_DIGITS bits: last captured value per digit, digit i at [4i+3:4i].
REQ-009 SHALL have port dp_out, output, N_DIGITS bits: last captured dp per digit.
REQ-010 SHALL have port blank_out, output, N_DIGITS bits: last capture of digit i was all-segments-off.
REQ-011 SHALL have port frame_strobe, output, 1 bit: one-cycle pulse when every digit has been captured since the previous pulse.
REQ-012 SHALL have port pattern_err, output, 1 bit: one-cycle pulse when a capture holds a non-BCD, non-blank pattern.
REQ-013 SHALL have port sel_err, output, 1 bit: one-cycle pulse on entry to the invalid-selection condition.

Function
REQ-014 SHALL pass Segments, dp and Digit_sel through a 2-stage synchronizer; all further logic uses the synchronized vector S.
REQ-015 SHALL decode only these patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00 (hex); every other pattern is invalid.
REQ-016 SHALL implement a state machine with states IDLE, SETTLE and HOLD.
REQ-017 IDLE -> SETTLE when S carries a valid selection; the stability counter loads 1.
REQ-018 In SETTLE, an S equal to the previous S increments the counter; any change reloads it to 1 and stays in SETTLE.
REQ-019 SETTLE -> HOLD when the counter reaches STABLE_CYCLES; the capture happens on that same edge.
REQ-020 HOLD -> SETTLE on any change of S while the selection stays valid; no second capture is made without a change.
REQ-021 Any state -> IDLE when the selection is invalid (zero or more than one bit low); sel_err pulses on the entry edge only.
REQ-022 Capture for digit i, valid pattern: bcd_out[i] = value; dp_out[i] = dp; blank_out[i] = 0.
REQ-023 Capture for digit i, blank pattern: bcd_out[i] = 4'hF; blank_out[i] = 1; dp_out[i] = dp.
REQ-024 Capture for digit i, invalid pattern: bcd_out[i] = 4'hE; blank_out[i] = 0; pattern_err pulses on the capture edge.
REQ-025 Capture latency: an input held constant on the ports is captured on rising edge STABLE_CYCLES+2, counting the first edge that samples the new value as edge 1.
REQ-026 An internal seen-mask SHALL set bit i on every capture of digit i.
REQ-027 When a capture completes the seen-mask, frame_strobe pulses on that same edge and the mask clears to zero; that capture does not carry over into the next frame.
REQ-028 Recapturing an already-seen digit SHALL update its outputs without altering the mask.
REQ-029 The stability counter SHALL be 8 bits and saturate, so it never wraps.

Reset
REQ-030 While rst_n is low: state=IDLE, counter=0, synchronizers=0, mask=0, bcd_out all 4'hF, blank_out all 1, dp_out all 0, frame_strobe=0, pattern_err=0, sel_err=0.
REQ-031 Reset asserted mid-SETTLE SHALL abort the pending capture with no output change other than the reset values.

Structure
REQ-032 Shared package seg7_pkg SHALL hold the eleven segment pattern constants, the codes 4'hE (error) and 4'hF (blank), and the state encoding.
REQ-033 The pattern-to-BCD decode SHALL be a combinational sub-module seg7_to_bcd (inputs: 7-bit pattern; outputs: 4-bit value, valid, blank), reusable elsewhere.

Verification
REQ-034 Scenario: drive Digit_sel=1110, Segments=4F for 30 cycles -> on edge 18, bcd_out[3:0]=3, blank_out[0]=0, no error pulse.
REQ-035 Scenario: scan digits 0..3 with patterns 06, 5B, 7F, 6F for 20 cycles each -> bcd_out=16'h9821, a single frame_strobe on digit 3's capture, mask cleared.
REQ-036 Scenario: Segments=49 held stable on digit 1 -> bcd_out[7:4]=E, one pattern_err pulse.
REQ-037 Scenario: Segments toggles every 10 cycles on digit 0 -> no capture ever occurs; outputs stay at their reset values.
REQ-038 Scenario: Digit_sel goes 1110 -> 1100 -> 1110 -> one sel_err pulse, IDLE, then a fresh 18-cycle capture.
REQ-039 Scenario: assert rst_n low at counter=10 -> all outputs at reset values, no frame_strobe.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment monitor: the eleven recognised
// segment patterns (bit order {g,f,e,d,c,b,a}, active-high), the special BCD
// codes written on capture, and the monitor state encoding.
`timescale 1ns/1ps
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_ERR   = 4'hE;  // captured pattern was not recognised
    localparam logic [3:0] BCD_BLANK = 4'hF;  // captured pattern was all segments off

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // no valid digit selected
        ST_SETTLE = 2'd1,  // counting identical samples
        ST_HOLD   = 2'd2   // captured; waiting for the inputs to change
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd
// Combinational decode of a seven-segment pattern to a BCD value.
// Ports:
//   pattern - 7-bit segment pattern {g,f,e,d,c,b,a}, active-high
//   value   - 0..9 for a digit, BCD_BLANK for all-off, BCD_ERR otherwise
//   valid   - pattern is one of the ten decimal digits
//   blank   - pattern is all segments off
`timescale 1ns/1ps
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank
);

    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        value = BCD_ERR;
        valid = 1'b1;
        blank = 1'b0;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                value = BCD_BLANK;
                valid = 1'b0;
                blank = 1'b1;
            end
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_cc_monitor.sv
// seg7_cc_monitor
// Observes a multiplexed common-cathode seven-segment display and recovers
// the value shown on each digit. Inputs are synchronised, and a digit is
// captured once the synchronised inputs have been identical for
// STABLE_CYCLES consecutive samples.
// Ports:
//   clk50MHz     - 50 MHz clock, rising edge
//   rst_n        - asynchronous active-low reset
//   Segments     - segment lines {g,f,e,d,c,b,a}, active-high
//   dp           - decimal point line, active-high
//   Digit_sel    - cathode selects, active-low, exactly one low is valid
//   bcd_out      - last captured value per digit, digit i at [4i+3:4i]
//   dp_out       - last captured decimal point per digit
//   blank_out    - last capture of the digit was all segments off
//   frame_strobe - one-cycle pulse when every digit has been captured
//   pattern_err  - one-cycle pulse when a capture held an unknown pattern
//   sel_err      - one-cycle pulse on entering an invalid selection
`timescale 1ns/1ps
module seg7_cc_monitor
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  clk50MHz,
    input  logic                  rst_n,
    input  logic [6:0]            Segments,
    input  logic                  dp,
    input  logic [N_DIGITS-1:0]   Digit_sel,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic [N_DIGITS-1:0]   dp_out,
    output logic [N_DIGITS-1:0]   blank_out,
    output logic                  frame_strobe,
    output logic                  pattern_err,
    output logic                  sel_err
);

    localparam int         S_W        = N_DIGITS + 8;
    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    // Synchronised input vector S = {Segments, dp, Digit_sel}
    logic [S_W-1:0] sync1_q, s_q, s_prev_q;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic                  frame_q, frame_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;

    logic [6:0]          s_seg;
    logic                s_dp;
    logic [N_DIGITS-1:0] s_sel;
    logic                sel_valid, prev_sel_valid, s_changed, capture;
    logic [3:0]          dec_value;
    logic                dec_valid, dec_blank;

    assign s_seg          = s_q[S_W-1 -: 7];
    assign s_dp           = s_q[N_DIGITS];
    assign s_sel          = s_q[N_DIGITS-1:0];
    assign sel_valid      = ($countones(~s_sel) == 1);
    assign prev_sel_valid = ($countones(~s_prev_q[N_DIGITS-1:0]) == 1);
    assign s_changed      = (s_q != s_prev_q);

    seg7_to_bcd u_decode (
        .pattern (s_seg),
        .value   (dec_value),
        .valid   (dec_valid),
        .blank   (dec_blank)
    );

    // State machine and stability counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!sel_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
                ST_SETTLE: begin
                    if (s_changed) begin
                        cnt_d = 8'd1;
                    end else begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        if (cnt_d >= STABLE_CNT) begin
                            state_d = ST_HOLD;
                            capture = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (s_changed) begin
                        state_d = ST_SETTLE;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Capture of the selected digit and frame tracking
    always_comb begin
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        perr_d  = 1'b0;
        // Pulse only on the transition from a valid to an invalid selection
        serr_d  = !sel_valid && prev_sel_valid;
        if (capture) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (!s_sel[i]) begin
                    bcd_d[4*i +: 4] = dec_value;
                    dp_d[i]         = s_dp;
                    blank_d[i]      = dec_blank;
                end
            end
            perr_d = !dec_valid && !dec_blank;
            seen_d = seen_q | ~s_sel;
            // The completing capture starts the next frame with an empty mask
            if (&seen_d) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            seen_q   <= '0;
            bcd_q    <= {N_DIGITS{BCD_BLANK}};
            dp_q     <= '0;
            blank_q  <= '1;
            frame_q  <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            sync1_q  <= {Segments, dp, Digit_sel};
            s_q      <= sync1_q;
            s_prev_q <= s_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            frame_q  <= frame_d;
            perr_q   <= perr_d;
            serr_q   <= serr_d;
        end
    end

    assign bcd_out      = bcd_q;
    assign dp_out       = dp_q;
    assign blank_out    = blank_q;
    assign frame_strobe = frame_q;
    assign pattern_err  = perr_q;
    assign sel_err      = serr_q;

endmodule

// File: tb/tb_seg7_cc_monitor.sv
// tb_seg7_cc_monitor
// Self-checking bench for seg7_cc_monitor. A reference model tracks the
// port history, measures how long the (two-cycle delayed) inputs have been
// identical, and applies the capture rules to produce expected outputs.
`timescale 1ns/1ps
module tb_seg7_cc_monitor;

    localparam int ND     = 4;
    localparam int STABLE = 16;
    localparam int IN_W   = ND + 8;
    localparam logic [26:0] RESET_BUNDLE = {16'hFFFF, 4'h0, 4'hF, 3'b000};
    localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic            clk50MHz = 1'b0;
    logic            rst_n;
    logic [6:0]      Segments = '0;
    logic            dp = 1'b0;
    logic [ND-1:0]   Digit_sel = '1;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0]   dp_out, blank_out;
    logic            frame_strobe, pattern_err, sel_err;

    int total = 0;
    int bad   = 0;

    always #10 clk50MHz = ~clk50MHz;

    seg7_cc_monitor #(.N_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
        .clk50MHz     (clk50MHz),
        .rst_n        (rst_n),
        .Segments     (Segments),
        .dp           (dp),
        .Digit_sel    (Digit_sel),
        .bcd_out      (bcd_out),
        .dp_out       (dp_out),
        .blank_out    (blank_out),
        .frame_strobe (frame_strobe),
        .pattern_err  (pattern_err),
        .sel_err      (sel_err)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [IN_W-1:0] h1;        // port value one edge ago
        logic [IN_W-1:0] h2;        // port value two edges ago
        logic [IN_W-1:0] last_vis;  // value seen by the monitor on the previous edge
        logic [7:0]      run;       // length of the current run of identical valid values
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   dpv;
        logic [ND-1:0]   blank;
        logic [ND-1:0]   seen;
        logic            frame;
        logic            perr;
        logic            serr;
    } model_t;

    model_t m;

    function automatic logic sel_ok(logic [ND-1:0] s);
        return $countones(~s) == 1;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r       = '0;
        r.bcd   = '1;
        r.blank = '1;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic [IN_W-1:0] port);
        model_t          n;
        logic [IN_W-1:0] vis;
        logic [6:0]      seg;
        logic            dv;
        logic [ND-1:0]   sel;
        logic [3:0]      code;
        logic            bl;
        int              idx;
        n   = cur;
        vis = cur.h2;
        seg = vis[IN_W-1 -: 7];
        dv  = vis[ND];
        sel = vis[ND-1:0];
        n.h2    = cur.h1;
        n.h1    = port;
        n.frame = 1'b0;
        n.perr  = 1'b0;
        n.serr  = 1'b0;
        if (sel_ok(sel)) begin
            if (cur.run != 0 && vis == cur.last_vis)
                n.run = (cur.run == 8'd255) ? cur.run : cur.run + 8'd1;
            else
                n.run = 8'd1;
            if (cur.run < STABLE && n.run >= STABLE) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (!sel[i]) idx = i;
                code = 4'hE;
                bl   = 1'b0;
                if (seg == 7'h00) begin
                    code = 4'hF;
                    bl   = 1'b1;
                end else begin
                    for (int d = 0; d < 10; d++) if (seg == PATS[d]) code = d[3:0];
                end
                n.bcd[4*idx +: 4] = code;
                n.dpv[idx]        = dv;
                n.blank[idx]      = bl;
                n.perr            = (code == 4'hE);
                n.seen[idx]       = 1'b1;
                if (&n.seen) begin
                    n.frame = 1'b1;
                    n.seen  = '0;
                end
            end
        end else begin
            n.run  = 8'd0;
            n.serr = sel_ok(cur.last_vis[ND-1:0]);
        end
        n.last_vis = vis;
        return n;
    endfunction

    always @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, {Segments, dp, Digit_sel});
    end

    wire [26:0] dut_bundle = {bcd_out, dp_out, blank_out, frame_strobe, pattern_err, sel_err};
    wire [26:0] exp_bundle = {m.bcd, m.dpv, m.blank, m.frame, m.perr, m.serr};

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [6:0] seg, input logic d, input logic [ND-1:0] sel);
        Segments  = seg;
        dp        = d;
        Digit_sel = sel;
    endtask

    task automatic do_reset();
        @(negedge clk50MHz);
        rst_n = 1'b0;
        drive(7'h00, 1'b0, '1);
        repeat (2) @(negedge clk50MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50MHz);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk50MHz);
        rst_n = 1'b0;
        drive(7'h3F, 1'b1, 4'b1110);
        repeat (3) @(negedge clk50MHz);
        total++;
        if (dut_bundle !== RESET_BUNDLE) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", dut_bundle, RESET_BUNDLE);
        end
        drive(7'h00, 1'b0, '1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk50MHz);
        total++;
        if (dut_bundle !== RESET_BUNDLE) begin
            bad++;
            $display("FAIL reset_released got=%h exp=%h", dut_bundle, RESET_BUNDLE);
        end
    endtask

    task automatic test_single_capture();
        int perr_cnt = 0;
        do_reset();
        drive(7'h4F, 1'b0, 4'b1110);
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk50MHz);
            if (pattern_err) perr_cnt++;
            if (e == 17) begin
                total++;
                if (bcd_out[3:0] !== 4'hF) begin
                    bad++;
                    $display("FAIL single_early edge=%0d got=%h exp=F", e, bcd_out[3:0]);
                end
            end
            if (e == 18) begin
                total++;
                if ({bcd_out[3:0], blank_out[0]} !== 5'b0011_0) begin
                    bad++;
                    $display("FAIL single_capture got bcd=%h blank=%b exp bcd=3 blank=0",
                             bcd_out[3:0], blank_out[0]);
                end
            end
        end
        total++;
        if (perr_cnt !== 0) begin
            bad++;
            $display("FAIL single_perr got=%0d exp=0", perr_cnt);
        end
    endtask

    task automatic test_frame_scan();
        logic [6:0]    segs [4] = '{7'h06, 7'h5B, 7'h7F, 7'h6F};
        logic [ND-1:0] sel;
        int            frame_cnt = 0;
        int            frame_digit = -1;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            sel    = '1;
            sel[d] = 1'b0;
            drive(segs[d], 1'b0, sel);
            repeat (20) begin
                @(negedge clk50MHz);
                total++;
                if (dut_bundle !== exp_bundle) begin
                    bad++;
                    $display("FAIL frame_model digit=%0d got=%h exp=%h", d, dut_bundle, exp_bundle);
                end
                if (frame_strobe) begin
                    frame_cnt++;
                    frame_digit = d;
                end
            end
        end
        total++;
        if (bcd_out !== 16'h9821) begin
            bad++;
            $display("FAIL frame_bcd got=%h exp=9821", bcd_out);
        end
        total++;
        if (frame_cnt !== 1 || frame_digit !== 3) begin
            bad++;
            $display("FAIL frame_count got=%0d at digit %0d exp=1 at digit 3", frame_cnt, frame_digit);
        end
        // A recapture right after the strobe starts a new frame and must not strobe
        drive(7'h3F, 1'b0, 4'b1110);
        repeat (20) begin
            @(negedge clk50MHz);
            if (frame_strobe) frame_cnt++;
        end
        total++;
        if (frame_cnt !== 1 || bcd_out !== 16'h9820) begin
            bad++;
            $display("FAIL frame_mask_cleared got frames=%0d bcd=%h exp frames=1 bcd=9820",
                     frame_cnt, bcd_out);
        end
    endtask

    task automatic test_bad_pattern();
        int perr_cnt = 0;
        do_reset();
        drive(7'h49, 1'b0, 4'b1101);
        repeat (25) begin
            @(negedge clk50MHz);
            if (pattern_err) perr_cnt++;
        end
        total++;
        if (bcd_out !== 16'hFFEF || blank_out[1] !== 1'b0) begin
            bad++;
            $display("FAIL bad_pattern got bcd=%h blank=%b exp bcd=FFEF blank[1]=0", bcd_out, blank_out);
        end
        total++;
        if (perr_cnt !== 1) begin
            bad++;
            $display("FAIL bad_pattern_pulses got=%0d exp=1", perr_cnt);
        end
    endtask

    task automatic test_toggle();
        int errs = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive((k % 2 == 0) ? 7'h3F : 7'h06, 1'b0, 4'b1110);
            repeat (10) begin
                @(negedge clk50MHz);
                total++;
                if (dut_bundle !== RESET_BUNDLE) begin
                    bad++;
                    errs++;
                    if (errs < 5)
                        $display("FAIL toggle_no_capture got=%h exp=%h", dut_bundle, RESET_BUNDLE);
                end
            end
        end
    endtask

    task automatic test_sel_err();
        int serr_cnt = 0;
        do_reset();
        drive(7'h4F, 1'b0, 4'b1110);
        repeat (25) @(negedge clk50MHz);
        total++;
        if (bcd_out[3:0] !== 4'h3) begin
            bad++;
            $display("FAIL sel_first_capture got=%h exp=3", bcd_out[3:0]);
        end
        drive(7'h4F, 1'b0, 4'b1100);
        repeat (10) begin
            @(negedge clk50MHz);
            if (sel_err) serr_cnt++;
        end
        drive(7'h5B, 1'b0, 4'b1110);
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk50MHz);
            if (sel_err) serr_cnt++;
            if (e == 17) begin
                total++;
                if (bcd_out[3:0] !== 4'h3) begin
                    bad++;
                    $display("FAIL sel_recapture_early got=%h exp=3", bcd_out[3:0]);
                end
            end
            if (e == 18) begin
                total++;
                if (bcd_out[3:0] !== 4'h2) begin
                    bad++;
                    $display("FAIL sel_recapture got=%h exp=2", bcd_out[3:0]);
                end
            end
        end
        total++;
        if (serr_cnt !== 1) begin
            bad++;
            $display("FAIL sel_err_pulses got=%0d exp=1", serr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int frame_cnt = 0;
        do_reset();
        drive(7'h06, 1'b0, 4'b1110);
        repeat (12) @(negedge clk50MHz);   // stability counter is at 10 here
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_bundle !== RESET_BUNDLE) begin
            bad++;
            $display("FAIL reset_mid_asserted got=%h exp=%h", dut_bundle, RESET_BUNDLE);
        end
        repeat (3) @(negedge clk50MHz);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk50MHz);
            if (frame_strobe) frame_cnt++;
            if (e == 17) begin
                total++;
                if (dut_bundle !== RESET_BUNDLE) begin
                    bad++;
                    $display("FAIL reset_mid_aborted got=%h exp=%h", dut_bundle, RESET_BUNDLE);
                end
            end
            if (e == 18) begin
                total++;
                if (bcd_out !== 16'hFFF1) begin
                    bad++;
                    $display("FAIL reset_mid_fresh got=%h exp=FFF1", bcd_out);
                end
            end
        end
        total++;
        if (frame_cnt !== 0) begin
            bad++;
            $display("FAIL reset_mid_frame got=%0d exp=0", frame_cnt);
        end
    endtask

    task automatic test_stable_boundary();
        int saw_five = 0;
        do_reset();
        drive(7'h6D, 1'b1, 4'b1011);       // one cycle short of a capture
        repeat (15) begin
            @(negedge clk50MHz);
            if (bcd_out[11:8] === 4'h5) saw_five++;
        end
        drive(7'h07, 1'b1, 4'b1011);       // exactly long enough
        repeat (16) begin
            @(negedge clk50MHz);
            if (bcd_out[11:8] === 4'h5) saw_five++;
        end
        drive(7'h00, 1'b0, 4'b1111);
        repeat (6) begin
            @(negedge clk50MHz);
            if (bcd_out[11:8] === 4'h5) saw_five++;
        end
        total++;
        if (saw_five !== 0 || bcd_out[11:8] !== 4'h7 || dp_out[2] !== 1'b1) begin
            bad++;
            $display("FAIL stable_boundary got bcd=%h dp=%b short_captures=%0d exp bcd[11:8]=7 dp[2]=1 0",
                     bcd_out, dp_out, saw_five);
        end
    endtask

    task automatic test_blank();
        do_reset();
        drive(7'h7F, 1'b0, 4'b0111);
        repeat (20) @(negedge clk50MHz);
        total++;
        if (bcd_out[15:12] !== 4'h8 || blank_out[3] !== 1'b0) begin
            bad++;
            $display("FAIL blank_pre got bcd=%h blank=%b exp 8 0", bcd_out[15:12], blank_out[3]);
        end
        drive(7'h00, 1'b1, 4'b0111);
        repeat (20) @(negedge clk50MHz);
        total++;
        if ({bcd_out[15:12], blank_out[3], dp_out[3], pattern_err} !== 7'b1111_110) begin
            bad++;
            $display("FAIL blank_capture got bcd=%h blank=%b dp=%b exp F 1 1",
                     bcd_out[15:12], blank_out[3], dp_out[3]);
        end
    endtask

    task automatic test_random();
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        int            errs = 0;
        do_reset();
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) < 8) begin
                sel = '1;
                sel[$urandom_range(0, ND - 1)] = 1'b0;
            end else begin
                sel = ND'($urandom);
            end
            case ($urandom_range(0, 9))
                0:          seg = 7'h00;
                1, 2, 3:    seg = 7'($urandom);
                default:    seg = PATS[$urandom_range(0, 9)];
            endcase
            drive(seg, 1'($urandom), sel);
            repeat ($urandom_range(1, 40)) begin
                @(negedge clk50MHz);
                total++;
                if (dut_bundle !== exp_bundle) begin
                    bad++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_model step=%0d got=%h exp=%h", t, dut_bundle, exp_bundle);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_single_capture();
        test_frame_scan();
        test_bad_pattern();
        test_toggle();
        test_sel_err();
        test_reset_mid();
        test_stable_boundary();
        test_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
